wb_com_master_nport: RTL and testbench

- Master-side port of the Wishbone commutator, generalised from two fixed slaves to NS parametrised slaves.
- Decodes each accepted pipelined request against a per-slave base/mask map and pushes it into that slave's header FIFO. Write data goes into that slave's data FIFO.
- Returns responses to the master strictly in issue order through an order FIFO of slave indices.
- Unmapped requests are answered with a single-cycle err.

---
 rtl/wb_com_master_nport_if.sv | 29 ++
 rtl/wb_com_master_nport.sv | 249 ++++++++++++++++++++++++
 tb/tb_wb_com_master_nport.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/wb_com_master_nport_if.sv
// Master-side Wishbone pipelined bus bundle for the commutator port.
// The master modport drives requests. The slave modport (the commutator) returns responses.
interface wb_com_master_nport_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int SEL_W = DW / 8;

  logic [AW-1:0]    m_wb_addr_o;
  logic [DW-1:0]    m_wb_dat_o;
  logic [SEL_W-1:0] m_wb_sel_o;
  logic             m_wb_cyc_o;
  logic             m_wb_stb_o;
  logic             m_wb_we_o;
  logic [DW-1:0]    m_wb_dat_i;
  logic             m_wb_stall_i;
  logic             m_wb_ack_i;
  logic             m_wb_err_i;

  modport master (
    output m_wb_addr_o, m_wb_dat_o, m_wb_sel_o, m_wb_cyc_o, m_wb_stb_o, m_wb_we_o,
    input  m_wb_dat_i, m_wb_stall_i, m_wb_ack_i, m_wb_err_i
  );

  modport slave (
    input  m_wb_addr_o, m_wb_dat_o, m_wb_sel_o, m_wb_cyc_o, m_wb_stb_o, m_wb_we_o,
    output m_wb_dat_i, m_wb_stall_i, m_wb_ack_i, m_wb_err_i
  );
endinterface

// File: rtl/wb_com_master_nport.sv
// Master-side commutator port with NS slaves.
// Requests are decoded against a base/mask map and queued per slave in a header FIFO and a
// write-data FIFO. Responses return to the master in issue order through a FIFO of slave indices.
// Unmapped requests get a one-cycle err.
// Optional feature: define WB_COM_MASTER_TIMEOUT_EN to add a response timeout (parameter TMO_W).
// When the timeout fires, the head is answered with err. The late response from that slave is
// then dropped silently.

// Synchronous FIFO. The pointers carry one extra wrap bit so full and empty can be told apart.
module wb_com_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  logic [W-1:0] mem [0:(1<<AW)-1];
  logic [AW:0]  wr_ptr, rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // storage write; contents need no reset, the pointers define validity
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  // pointer update; a simultaneous push and pop leaves occupancy unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// Per-slave queues. The header and write-data FIFOs keep independent pointers,
// because the slave pops data only for writes.
module wb_com_slave_chan #(
  parameter int HDR_W   = 41,
  parameter int DW      = 32,
  parameter int FIFO_AW = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_h,
  input  logic             push_d,
  input  logic [HDR_W-1:0] hdr_in,
  input  logic [DW-1:0]    dat_in,
  input  logic             hrden,
  input  logic             drden,
  output logic [HDR_W-1:0] hdr_out,
  output logic [DW-1:0]    dat_out,
  output logic             hempty,
  output logic             hfull
);
  logic dempty_unused, dfull_unused;

  wb_com_fifo #(.W(HDR_W), .AW(FIFO_AW)) u_hdr (
    .clk(clk), .rst(rst), .push(push_h), .din(hdr_in), .pop(hrden),
    .dout(hdr_out), .empty(hempty), .full(hfull)
  );

  // Data never outruns headers, so a full data FIFO implies a full header FIFO.
  // The header's full flag therefore covers both FIFOs.
  wb_com_fifo #(.W(DW), .AW(FIFO_AW)) u_dat (
    .clk(clk), .rst(rst), .push(push_d), .din(dat_in), .pop(drden),
    .dout(dat_out), .empty(dempty_unused), .full(dfull_unused)
  );
endmodule

module wb_com_master_nport #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int TAG_W    = 4,
  parameter int NS       = 4,
  parameter int IDX_W    = 2,
  parameter int FIFO_AW  = 2,
  parameter int OUTST_AW = 3,
  parameter logic [NS*AW-1:0] S_BASE = {32'h30000000, 32'h20000000, 32'h10000000, 32'h00000000},
  parameter logic [NS*AW-1:0] S_MASK = {4{32'h0FFFFFFF}}
`ifdef WB_COM_MASTER_TIMEOUT_EN
  , parameter int TMO_W = 8
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  wb_com_master_nport_if.slave bus,
  input  logic [TAG_W-1:0]     time_tag,
  output logic [NS*(AW+DW/8+1+TAG_W)-1:0] m_to_s_header_o,
  input  logic [NS-1:0]        m_to_s_hrden,
  output logic [NS-1:0]        m_to_s_hempty,
  output logic [NS*DW-1:0]     m_to_s_data_o,
  input  logic [NS-1:0]        m_to_s_drden,
  input  logic [NS*DW-1:0]     s_to_m_data_o,
  input  logic [NS-1:0]        s_to_m_dempty,
  output logic [NS-1:0]        s_to_m_drden
);
  localparam int SEL_W = DW / 8;
  localparam int HDR_W = AW + SEL_W + 1 + TAG_W;
  localparam int ORD_W = 1 + IDX_W;

  logic [NS-1:0][AW-1:0]    base, mask;
  logic [NS-1:0][DW-1:0]    rsp_data;
  logic [NS-1:0][HDR_W-1:0] hdr_q;
  logic [NS-1:0][DW-1:0]    dat_q;
  logic [NS-1:0]            hit, hfull;
  logic [IDX_W-1:0]         hit_idx;
  logic                     mapped, stall, accept;
  logic [HDR_W-1:0]         hdr_in;

  logic [ORD_W-1:0] ord_dout;
  logic             ord_empty, ord_full, ord_valid, ord_err, ord_pop;
  logic [IDX_W-1:0] ord_idx;
  logic             ack, err;

  assign base            = S_BASE;
  assign mask            = S_MASK;
  assign rsp_data        = s_to_m_data_o;
  assign m_to_s_header_o = hdr_q;
  assign m_to_s_data_o   = dat_q;

  // address decode: lowest-index hit wins, no hit means unmapped
  always_comb begin
    for (int i = 0; i < NS; i++)
      hit[i] = ((bus.m_wb_addr_o & ~mask[i]) == base[i]);
    hit_idx = '0;
    mapped  = 1'b0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        mapped  = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Stall depends only on the current address. Unmapped requests see only the order FIFO.
  assign stall  = ord_full | (mapped & hfull[hit_idx]);
  assign accept = bus.m_wb_cyc_o & bus.m_wb_stb_o & ~stall;
  assign hdr_in = {bus.m_wb_addr_o, bus.m_wb_sel_o, bus.m_wb_we_o, time_tag};

  for (genvar i = 0; i < NS; i++) begin : g_chan
    logic sel_here;
    assign sel_here = accept & mapped & (hit_idx == IDX_W'(i));
    wb_com_slave_chan #(.HDR_W(HDR_W), .DW(DW), .FIFO_AW(FIFO_AW)) u_chan (
      .clk(clk), .rst(rst),
      .push_h(sel_here), .push_d(sel_here & bus.m_wb_we_o),
      .hdr_in(hdr_in), .dat_in(bus.m_wb_dat_o),
      .hrden(m_to_s_hrden[i]), .drden(m_to_s_drden[i]),
      .hdr_out(hdr_q[i]), .dat_out(dat_q[i]),
      .hempty(m_to_s_hempty[i]), .hfull(hfull[i])
    );
  end

  // issue-order record: {err, slave index} for every accepted request
  wb_com_fifo #(.W(ORD_W), .AW(OUTST_AW)) u_order (
    .clk(clk), .rst(rst), .push(accept), .din({~mapped, hit_idx}), .pop(ord_pop),
    .dout(ord_dout), .empty(ord_empty), .full(ord_full)
  );

  assign ord_valid = ~ord_empty;
  assign ord_err   = ord_dout[IDX_W];
  // force slice 0 when idle so dat_i is well defined after reset
  assign ord_idx   = ord_valid ? ord_dout[IDX_W-1:0] : '0;

`ifdef WB_COM_MASTER_TIMEOUT_EN
  logic [TMO_W-1:0]     tmo_cnt;
  logic [NS-1:0][2:0]   discard;
  logic [NS-1:0]        dis_inc, dis_dec;
  logic                 tmo_fire;

  // response routing; a slave owing discards has its responses swallowed before any ack
  always_comb begin
    ack          = 1'b0;
    err          = 1'b0;
    tmo_fire     = 1'b0;
    s_to_m_drden = '0;
    dis_inc      = '0;
    dis_dec      = '0;
    for (int k = 0; k < NS; k++) begin
      if (discard[k] != 3'd0 && !s_to_m_dempty[k]) begin
        s_to_m_drden[k] = 1'b1;
        dis_dec[k]      = 1'b1;
      end
    end
    if (ord_valid) begin
      if (ord_err) begin
        err = 1'b1;
      end else if (!s_to_m_dempty[ord_idx] && discard[ord_idx] == 3'd0) begin
        ack                   = 1'b1;
        s_to_m_drden[ord_idx] = 1'b1;
      end else if (tmo_cnt == '1) begin
        err              = 1'b1;
        tmo_fire         = 1'b1;
        dis_inc[ord_idx] = 1'b1;
      end
    end
  end

  // wait counter for the current head, restarted whenever the head changes
  always_ff @(posedge clk) begin
    if (rst || ord_pop || !ord_valid || ord_err) tmo_cnt <= '0;
    else                                         tmo_cnt <= tmo_cnt + 1'b1;
  end

  // per-slave count of abandoned responses still to arrive (saturating)
  always_ff @(posedge clk) begin
    if (rst) begin
      discard <= '0;
    end else begin
      for (int k = 0; k < NS; k++) begin
        if (dis_inc[k] && !dis_dec[k] && discard[k] != 3'd7) discard[k] <= discard[k] + 3'd1;
        else if (dis_dec[k] && !dis_inc[k])                  discard[k] <= discard[k] - 3'd1;
      end
    end
  end
`else
  // response routing: the head waits for its own slave, which gives strict in-order return
  always_comb begin
    ack          = 1'b0;
    err          = 1'b0;
    s_to_m_drden = '0;
    if (ord_valid) begin
      if (ord_err) begin
        err = 1'b1;
      end else if (!s_to_m_dempty[ord_idx]) begin
        ack                   = 1'b1;
        s_to_m_drden[ord_idx] = 1'b1;
      end
    end
  end
`endif

  assign ord_pop          = ack | err;
  assign bus.m_wb_ack_i   = ack;
  assign bus.m_wb_err_i   = err;
  assign bus.m_wb_stall_i = stall;
  assign bus.m_wb_dat_i   = rsp_data[ord_idx];
endmodule

// File: tb/tb_wb_com_master_nport.sv
// Directed bench for wb_com_master_nport: decode, per-slave queues, ordering, err, stall, reset.
module tb_wb_com_master_nport;
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      time_tag = '0;
  logic [3:0][40:0] hdr;
  logic [3:0]      hrden = '0;
  logic [3:0]      hempty;
  logic [3:0][31:0] wdat;
  logic [3:0]      wdrden = '0;
  logic [3:0][31:0] rsp = '0;
  logic [3:0]      rsp_empty = 4'hF;
  logic [3:0]      rsp_rden;
  int total = 0;
  int bad   = 0;

  wb_com_master_nport_if #(.AW(32), .DW(32)) bus ();

  wb_com_master_nport dut (
    .clk(clk), .rst(rst), .bus(bus), .time_tag(time_tag),
    .m_to_s_header_o(hdr), .m_to_s_hrden(hrden), .m_to_s_hempty(hempty),
    .m_to_s_data_o(wdat), .m_to_s_drden(wdrden),
    .s_to_m_data_o(rsp), .s_to_m_dempty(rsp_empty), .s_to_m_drden(rsp_rden)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.m_wb_addr_o = '0; bus.m_wb_dat_o = '0; bus.m_wb_sel_o = '0;
    bus.m_wb_cyc_o = 1'b0; bus.m_wb_stb_o = 1'b0; bus.m_wb_we_o = 1'b0;

    // reset and idle
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_stall", 64'(bus.m_wb_stall_i), 64'd0);
    check("rst_ack", 64'(bus.m_wb_ack_i), 64'd0);
    check("rst_err", 64'(bus.m_wb_err_i), 64'd0);
    check("rst_hempty", 64'(hempty), 64'hF);
    check("rst_drden", 64'(rsp_rden), 64'd0);

    // single write to slave 2
    bus.m_wb_cyc_o = 1'b1; bus.m_wb_stb_o = 1'b1; bus.m_wb_we_o = 1'b1;
    bus.m_wb_addr_o = 32'h20000010; bus.m_wb_dat_o = 32'hDEADBEEF; bus.m_wb_sel_o = 4'hF;
    time_tag = 4'h5;
    #1;
    check("wr_stall", 64'(bus.m_wb_stall_i), 64'd0);
    tick();
    bus.m_wb_stb_o = 1'b0; bus.m_wb_we_o = 1'b0;
    #1;
    check("wr_hempty", 64'(hempty), 64'hB);
    check("wr_header", 64'(hdr[2]), {23'd0, 32'h20000010, 4'hF, 1'b1, 4'h5});
    check("wr_data", 64'(wdat[2]), 64'hDEADBEEF);
    check("wr_noack", 64'(bus.m_wb_ack_i), 64'd0);
    rsp[2] = 32'h12345678; rsp_empty[2] = 1'b0; hrden[2] = 1'b1; wdrden[2] = 1'b1;
    #1;
    check("wr_ack", 64'(bus.m_wb_ack_i), 64'd1);
    check("wr_dat_i", 64'(bus.m_wb_dat_i), 64'h12345678);
    check("wr_rsp_rden", 64'(rsp_rden), 64'h4);
    tick();
    rsp_empty[2] = 1'b1; hrden = '0; wdrden = '0;
    #1;
    check("wr_ack_done", 64'(bus.m_wb_ack_i), 64'd0);
    check("wr_hempty_done", 64'(hempty), 64'hF);

    // reads to slave 1 then slave 0; slave 0 answers first but must wait
    bus.m_wb_stb_o = 1'b1; bus.m_wb_addr_o = 32'h10000004;
    tick();
    bus.m_wb_addr_o = 32'h00000008;
    tick();
    bus.m_wb_stb_o = 1'b0;
    #1;
    check("rd_hempty", 64'(hempty), 64'hC);
    rsp[0] = 32'h0000AAAA; rsp_empty[0] = 1'b0;
    #1;
    check("rd_wait0", 64'(bus.m_wb_ack_i), 64'd0);
    tick();
    check("rd_wait1", 64'(bus.m_wb_ack_i), 64'd0);
    tick();
    check("rd_wait2", 64'(bus.m_wb_ack_i), 64'd0);
    tick();
    check("rd_wait3", 64'(bus.m_wb_ack_i), 64'd0);
    rsp[1] = 32'h1111BBBB; rsp_empty[1] = 1'b0;
    #1;
    check("rd_ack1", 64'(bus.m_wb_ack_i), 64'd1);
    check("rd_dat1", 64'(bus.m_wb_dat_i), 64'h1111BBBB);
    check("rd_rden1", 64'(rsp_rden), 64'h2);
    tick();
    rsp_empty[1] = 1'b1;
    #1;
    check("rd_ack0", 64'(bus.m_wb_ack_i), 64'd1);
    check("rd_dat0", 64'(bus.m_wb_dat_i), 64'h0000AAAA);
    check("rd_rden0", 64'(rsp_rden), 64'h1);
    tick();
    rsp_empty[0] = 1'b1;
    #1;
    check("rd_ack_done", 64'(bus.m_wb_ack_i), 64'd0);
    hrden = 4'h3;
    tick();
    hrden = '0;
    #1;
    check("rd_hempty_done", 64'(hempty), 64'hF);

    // unmapped read
    bus.m_wb_stb_o = 1'b1; bus.m_wb_addr_o = 32'h40000000;
    #1;
    check("um_stall", 64'(bus.m_wb_stall_i), 64'd0);
    tick();
    bus.m_wb_stb_o = 1'b0;
    #1;
    check("um_err", 64'(bus.m_wb_err_i), 64'd1);
    check("um_ack", 64'(bus.m_wb_ack_i), 64'd0);
    check("um_hempty", 64'(hempty), 64'hF);
    tick();
    check("um_err_once", 64'(bus.m_wb_err_i), 64'd0);

    // fill slave 3: the header FIFO stalls at 4, then the order FIFO stalls at 8
    bus.m_wb_stb_o = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.m_wb_addr_o = 32'h30000000 + 32'(i * 4);
      #1;
      check("fill_stall0", 64'(bus.m_wb_stall_i), 64'd0);
      tick();
    end
    bus.m_wb_addr_o = 32'h30000010;
    #1;
    check("hfull_stall", 64'(bus.m_wb_stall_i), 64'd1);
    check("hfull_hempty", 64'(hempty), 64'h7);
    for (int i = 4; i < 8; i++) begin
      hrden[3] = 1'b1;
      tick();
      hrden[3] = 1'b0;
      bus.m_wb_addr_o = 32'h30000000 + 32'(i * 4);
      #1;
      check("pop_unstall", 64'(bus.m_wb_stall_i), 64'd0);
      tick();
    end
    hrden[3] = 1'b1;
    tick();
    hrden[3] = 1'b0;
    #1;
    check("ofull_stall", 64'(bus.m_wb_stall_i), 64'd1);
    bus.m_wb_addr_o = 32'h40000000;
    #1;
    check("ofull_unmapped", 64'(bus.m_wb_stall_i), 64'd1);
    check("ofull_noack", 64'(bus.m_wb_ack_i), 64'd0);

    // reset with requests outstanding
    bus.m_wb_stb_o = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rsp[0] = 32'hC0C0C0C0;
    #1;
    check("rst2_hempty", 64'(hempty), 64'hF);
    check("rst2_stall", 64'(bus.m_wb_stall_i), 64'd0);
    check("rst2_ack", 64'(bus.m_wb_ack_i), 64'd0);
    check("rst2_err", 64'(bus.m_wb_err_i), 64'd0);
    check("rst2_rden", 64'(rsp_rden), 64'd0);
    check("rst2_dat", 64'(bus.m_wb_dat_i), 64'hC0C0C0C0);
    rsp[3] = 32'h33333333; rsp_empty[3] = 1'b0;
    #1;
    check("late_ack", 64'(bus.m_wb_ack_i), 64'd0);
    check("late_rden", 64'(rsp_rden), 64'd0);
    tick();
    check("late_ack2", 64'(bus.m_wb_ack_i), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
